// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: round-robin owner of the shared RGB LED with minimum
// hold, dark gap between owners and glitch-free registered PWM outputs.
// Ports: clk, resetn (sync, active-low), req[NREQ], colour[NREQ*3*PWM_BITS],
//        grant[NREQ] (one-hot), busy, pwm_red/pwm_green/pwm_blue.
module rgb_led_arbiter #(
  parameter int NREQ         = 4,
  parameter int PWM_BITS     = 8,
  parameter int HOLD_CYCLES  = 4800000,
  parameter int BLANK_CYCLES = 48000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*3*PWM_BITS-1:0] colour,
  output logic [NREQ-1:0]            grant,
  output logic                       busy,
  output logic                       pwm_red,
  output logic                       pwm_green,
  output logic                       pwm_blue
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = 3 * PWM_BITS;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int BW = $clog2(BLANK_CYCLES) + 1;

  localparam logic [HW-1:0]   HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [BW-1:0]   BLANK_END = BW'(BLANK_CYCLES - 1);
  localparam logic [NREQ-1:0] ONE       = NREQ'(1);
  localparam logic [IW-1:0]   PTR_RST   = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    BLANK
  } state_t;

  state_t              state;
  logic [IW-1:0]       owner;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       winner;
  logic [IW-1:0]       idx;
  logic                found;
  logic [HW-1:0]       hold_cnt;
  logic [BW-1:0]       blank_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_r;
  logic [PWM_BITS-1:0] duty_g;
  logic [PWM_BITS-1:0] duty_b;
  logic [CW-1:0]       slice;
  logic                own_req;
  logic                others;

  // First requester after ptr, wrapping modulo NREQ.
  always_comb begin
    winner = ptr;
    idx    = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    slice = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IW'(i)) slice = colour[i*CW +: CW];
    end
  end

  // grant is one-hot on the owner while in OWN.
  assign own_req = |(req & grant);
  assign others  = |(req & ~grant);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      grant     <= '0;
      busy      <= 1'b0;
      owner     <= '0;
      ptr       <= PTR_RST;
      hold_cnt  <= '0;
      blank_cnt <= '0;
      pwm_cnt   <= '0;
      duty_r    <= '0;
      duty_g    <= '0;
      duty_b    <= '0;
      pwm_red   <= 1'b0;
      pwm_green <= 1'b0;
      pwm_blue  <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + 1'b1;
      pwm_red   <= (pwm_cnt < duty_r);
      pwm_green <= (pwm_cnt < duty_g);
      pwm_blue  <= (pwm_cnt < duty_b);
      unique case (state)
        IDLE: begin
          if (|req) begin
            state    <= OWN;
            owner    <= winner;
            grant    <= ONE << winner;
            hold_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        OWN: begin
          // Owner drop wins over hold expiry; both end in BLANK.
          if (!own_req || (hold_cnt >= HOLD_MAX && others)) begin
            state     <= BLANK;
            grant     <= '0;
            ptr       <= owner;
            duty_r    <= '0;
            duty_g    <= '0;
            duty_b    <= '0;
            blank_cnt <= '0;
          end else begin
            if (hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
            // Reload only at the period boundary so a period is never cut.
            if (pwm_cnt == '1) begin
              duty_r <= slice[CW-1 -: PWM_BITS];
              duty_g <= slice[2*PWM_BITS-1 -: PWM_BITS];
              duty_b <= slice[PWM_BITS-1:0];
            end
          end
        end
        BLANK: begin
          if (blank_cnt == BLANK_END) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter: directed stimulus with a cycle-stamped scoreboard
// for rgb_led_arbiter (NREQ=4, PWM_BITS=4, HOLD=16, BLANK=4).
module tb_rgb_led_arbiter;

  localparam int NREQ  = 4;
  localparam int PB    = 4;
  localparam int HOLD  = 16;
  localparam int BLANK = 4;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic [NREQ-1:0]        req;
  logic [NREQ*3*PB-1:0]   colour;
  logic [NREQ-1:0]        grant;
  logic                   busy;
  logic                   pwm_red;
  logic                   pwm_green;
  logic                   pwm_blue;

  rgb_led_arbiter #(
    .NREQ        (NREQ),
    .PWM_BITS    (PB),
    .HOLD_CYCLES (HOLD),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req),
    .colour   (colour),
    .grant    (grant),
    .busy     (busy),
    .pwm_red  (pwm_red),
    .pwm_green(pwm_green),
    .pwm_blue (pwm_blue)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    bit         is_pwm;
    logic [3:0] gnt;
    logic       bsy;
    logic [2:0] pwm;
  } exp_t;

  exp_t q[$];
  int   edge_n = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   R;

  task automatic exp_gb(int c, string nm, logic [3:0] g, logic b);
    exp_t e;
    e.cyc = c; e.name = nm; e.is_pwm = 1'b0;
    e.gnt = g; e.bsy = b; e.pwm = '0;
    q.push_back(e);
  endtask

  task automatic exp_pwm(int c, string nm, logic [2:0] p);
    exp_t e;
    e.cyc = c; e.name = nm; e.is_pwm = 1'b1;
    e.gnt = '0; e.bsy = 1'b0; e.pwm = p;
    q.push_back(e);
  endtask

  // r0 is the reset edge; pwm_cnt before edge c is (c-1-r0) mod 16.
  task automatic exp_pattern(int c0, int n, int r0, int dr, int dg, int db,
                             string nm);
    for (int i = 0; i < n; i++) begin
      int c;
      int j;
      logic [2:0] p;
      c = c0 + i;
      j = (c - 1 - r0) % 16;
      p = {j < dr, j < dg, j < db};
      exp_pwm(c, nm, p);
    end
  endtask

  task automatic wait_until(int c);
    while (edge_n < c) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    resetn = 1'b0;
    req    = '0;
    colour = '0;
    R      = edge_n + 1;
    exp_gb(R, "rst_gb", 4'b0000, 1'b0);
    exp_pwm(R, "rst_pwm", 3'b000);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Monitor: samples 1 time unit after each edge and retires due entries.
  always @(posedge clk) begin
    edge_n++;
    #1;
    n_cmp++;
    if (!$onehot0(grant)) begin
      n_bad++;
      $display("FAIL onehot cyc=%0d grant=%b want at most one bit",
               edge_n, grant);
    end
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= edge_n) begin
        n_cmp++;
        if (q[i].cyc < edge_n) begin
          n_bad++;
          $display("FAIL %s stale entry cyc=%0d now=%0d",
                   q[i].name, q[i].cyc, edge_n);
        end else if (q[i].is_pwm) begin
          if ({pwm_red, pwm_green, pwm_blue} !== q[i].pwm) begin
            n_bad++;
            $display("FAIL %s cyc=%0d rgb=%b want %b", q[i].name,
                     edge_n, {pwm_red, pwm_green, pwm_blue}, q[i].pwm);
          end
        end else begin
          if (grant !== q[i].gnt || busy !== q[i].bsy) begin
            n_bad++;
            $display("FAIL %s cyc=%0d grant=%b busy=%b want grant=%b busy=%b",
                     q[i].name, edge_n, grant, busy, q[i].gnt, q[i].bsy);
          end
        end
        q.delete(i);
      end
    end
  end

  initial begin
    // 1: reset held 3 edges with all requests up, then requester 0 first.
    resetn = 1'b0;
    req    = 4'hF;
    colour = '0;
    for (int c = 1; c <= 3; c++) begin
      exp_gb(c, "t1_reset", 4'b0000, 1'b0);
      exp_pwm(c, "t1_pwm", 3'b000);
    end
    wait_until(3);
    resetn = 1'b1;
    exp_gb(4, "t1_first", 4'b0001, 1'b1);
    wait_until(4);
    req = '0;

    // 2: single requester 2, colour r=4 g=0 b=15.
    reset_dut();
    colour[2*12 +: 12] = 12'h40F;
    req = 4'b0100;
    exp_gb(R + 1, "t2_grant", 4'b0100, 1'b1);
    exp_pwm(R + 16, "t2_dark", 3'b000);
    exp_pattern(R + 17, 32, R, 4, 0, 15, "t2_pwm");
    exp_gb(R + 49, "t2_release", 4'b0000, 1'b1);
    exp_pwm(R + 49, "t2_last", 3'b101);
    exp_pwm(R + 50, "t2_off", 3'b000);
    exp_gb(R + 52, "t2_blank", 4'b0000, 1'b1);
    exp_gb(R + 53, "t2_idle", 4'b0000, 1'b0);
    wait_until(R + 48);
    req = '0;
    wait_until(R + 53);

    // 3: requesters 0 and 1 contend; hold expiry rotates ownership.
    reset_dut();
    req = 4'b0011;
    exp_gb(R + 1,  "t3_own0",  4'b0001, 1'b1);
    exp_gb(R + 17, "t3_hold0", 4'b0001, 1'b1);
    exp_gb(R + 18, "t3_pre0",  4'b0000, 1'b1);
    exp_gb(R + 21, "t3_dark",  4'b0000, 1'b1);
    exp_gb(R + 22, "t3_idle",  4'b0000, 1'b0);
    exp_gb(R + 23, "t3_own1",  4'b0010, 1'b1);
    exp_gb(R + 39, "t3_hold1", 4'b0010, 1'b1);
    exp_gb(R + 40, "t3_pre1",  4'b0000, 1'b1);
    exp_gb(R + 45, "t3_back0", 4'b0001, 1'b1);
    wait_until(R + 45);

    // 4: owner drop releases at once, then owner 1 drops after 5 cycles.
    req = 4'b0010;
    exp_gb(R + 46, "t4_drop0", 4'b0000, 1'b1);
    exp_gb(R + 50, "t4_idle",  4'b0000, 1'b0);
    exp_gb(R + 51, "t4_own1",  4'b0010, 1'b1);
    exp_gb(R + 55, "t4_held",  4'b0010, 1'b1);
    exp_gb(R + 56, "t4_drop1", 4'b0000, 1'b1);
    exp_pwm(R + 57, "t4_dark", 3'b000);
    wait_until(R + 55);
    req = '0;
    wait_until(R + 56);
    req = 4'b0001;
    exp_gb(R + 57, "t4_ignore",  4'b0000, 1'b1);
    exp_gb(R + 60, "t4_gap",     4'b0000, 1'b0);
    exp_gb(R + 61, "t4_regrant", 4'b0001, 1'b1);
    wait_until(R + 61);

    // 5: colour change mid-period takes effect after the next wrap.
    reset_dut();
    colour[0 +: 12] = 12'h280;
    req = 4'b0001;
    exp_gb(R + 1, "t5_grant", 4'b0001, 1'b1);
    exp_pattern(R + 17, 16, R, 2, 8, 0, "t5_old");
    exp_pattern(R + 33, 16, R, 10, 1, 5, "t5_new");
    wait_until(R + 22);
    colour[0 +: 12] = 12'hA15;
    wait_until(R + 48);

    // 6: reset pulse while owner 3 is lit.
    reset_dut();
    colour[3*12 +: 12] = 12'hFFF;
    req = 4'b1000;
    exp_gb(R + 1, "t6_own3", 4'b1000, 1'b1);
    exp_pattern(R + 17, 4, R, 15, 15, 15, "t6_pwm");
    exp_gb(R + 20, "t6_held", 4'b1000, 1'b1);
    wait_until(R + 20);
    resetn = 1'b0;
    req    = 4'b1001;
    exp_gb(R + 21, "t6_rst", 4'b0000, 1'b0);
    exp_pwm(R + 21, "t6_rst_pwm", 3'b000);
    wait_until(R + 21);
    resetn = 1'b1;
    exp_gb(R + 22, "t6_first0", 4'b0001, 1'b1);
    exp_pwm(R + 22, "t6_dark", 3'b000);
    wait_until(R + 24);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    foreach (q[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s cyc=%0d never checked", q[i].name, q[i].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
